// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant holding, a bounded hold time and a dead cycle between grants.
// Fairness: the next winner is the lowest pending index above the last-granted one, wrapping around.
module rr_hold_arbiter #(
    parameter int request_lines = 4,
    parameter int max_hold      = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [request_lines-1:0]         req,
    output logic [request_lines-1:0]         gnt,
    output logic                             gnt_valid,
    output logic [$clog2(request_lines)-1:0] gnt_id,
    output logic                             preempt
);
    localparam int IW = $clog2(request_lines);
    localparam int HW = (max_hold > 1) ? $clog2(max_hold) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(request_lines - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(max_hold - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        GAP
    } state_t;

    state_t                   state_q, state_d;
    logic [request_lines-1:0] gnt_q, gnt_d;
    logic                     gnt_valid_q, gnt_valid_d;
    logic [IW-1:0]            gnt_id_q, gnt_id_d;
    logic                     preempt_q, preempt_d;
    logic [IW-1:0]            last_q, last_d;
    logic [HW-1:0]            hold_q, hold_d;

    logic [request_lines-1:0] mask;
    logic [request_lines-1:0] masked;
    logic                     win_found;
    logic [IW-1:0]            win_id;
    logic                     others_pending;

    // Prefer the lowest pending index above last; fall back to the lowest pending index overall.
    always_comb begin
        mask      = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < request_lines; i++) begin
            if (i > int'(last_q)) begin
                mask[i] = 1'b1;
            end
        end
        masked = req & mask;
        for (int i = request_lines - 1; i >= 0; i--) begin
            if (masked[i]) begin
                win_found = 1'b1;
                win_id    = IW'(i);
            end
        end
        if (!win_found) begin
            for (int i = request_lines - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_found = 1'b1;
                    win_id    = IW'(i);
                end
            end
        end
    end

    assign others_pending = |(req & ~gnt_q);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (win_found) begin
                    state_d  = OWN;
                    gnt_d    = request_lines'(1) << win_id;
                    gnt_id_d = win_id;
                    last_d   = win_id;
                    hold_d   = '0;
                end else begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
            end
            OWN: begin
                if (!req[gnt_id_q]) begin
                    state_d  = GAP;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end else if (hold_q == HOLD_MAX && others_pending) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    preempt_d = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    // Reset wins over everything, including a grant in progress (no GAP cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            preempt_q   <= 1'b0;
            last_q      <= LAST_RST;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            preempt_q   <= preempt_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign preempt   = preempt_q;
endmodule

// File: doc/rr_hold_arbiter.md
# rr_hold_arbiter

Round-robin arbiter that shares one downstream resource among `request_lines` requesters with grant holding. A grant persists while its requester keeps `req` high, up to `max_hold` cycles. Fairness uses a thermometer mask of requesters strictly above the last-granted index, so the next winner is the lowest pending index above it, wrapping to the lowest pending index overall. Sits in front of the shared resource; `gnt`/`gnt_id` drive its select mux.

## Interface
- `request_lines`, default 4: number of requesters. Must be ≥2.
- `max_hold`, default 8: maximum consecutive grant cycles before forced handover when others are pending. Must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  `request_lines`  request vector; bit i held high while requester i wants the resource.
- `gnt`  out  `request_lines`  registered one-hot grant, or all-zero.
- `gnt_valid`  out  1  equal to `|gnt`, registered.
- `gnt_id`  out  `$clog2(request_lines)`  index of the granted requester; 0 when `gnt_valid`=0.
- `preempt`  out  1  one-cycle pulse in the cycle after a grant is removed by the `max_hold` limit.

## Operation
- State machine:
  - IDLE: no grant.
  - OWN: grant held.
  - GAP: one dead cycle between grants, for resource turnaround.
- Registers:
  - `last`: index of the last granted requester.
  - `hold_cnt`: 0 to `max_hold`-1.
- Winner selection is combinational on the current `req` and `last`:
  - `mask`: bits (`last`+1) to `request_lines`-1 set, all others clear.
  - If `req & mask` ≠ 0, winner = lowest set bit of `req & mask`.
  - Otherwise, winner = lowest set bit of `req`.
  - If `req` = 0, there is no winner.
- IDLE or GAP with a winner: next state is OWN. Load `gnt` (one-hot winner), `gnt_id`, and `last` = winner; clear `hold_cnt`.
- IDLE or GAP without a winner: next state is IDLE.
- OWN, granted `req` bit low: release. Next state is GAP; `gnt` clears.
- OWN, granted bit high, `hold_cnt` = `max_hold`-1, and some other `req` bit set: forced handover. Next state is GAP; `gnt` clears; `preempt`=1 for one cycle.
- OWN, granted bit high, otherwise: remain in OWN and increment `hold_cnt`. `hold_cnt` saturates at `max_hold`-1 while no other requester is pending.
- `gnt` is never multi-hot. `gnt` never changes directly from one requester to another; there is always a GAP cycle between grants.
- A requester that drops `req` while not granted is simply skipped; there is no request latching.

## Timing
- Reset, while `rst`=1 at a clock edge:
  - state IDLE.
  - `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `preempt`=0.
  - `hold_cnt`=0.
  - `last`=`request_lines`-1, so index 0 has first priority.
- Reset asserted mid-grant drops `gnt` at that same edge, with no GAP cycle.
- Grant latency: `req` sampled high at edge t in IDLE gives `gnt` high after edge t (visible in cycle t+1).
- Release: granted `req` low in cycle t gives `gnt`=0 in cycle t+1 (GAP). The earliest next grant is cycle t+2.
- Hold limit: with continuous competition, a requester owns exactly `max_hold` consecutive cycles, followed by 1 GAP cycle.
- `max_hold`=1: every grant lasts one cycle when others are pending.
- Same requester re-requests in GAP and is the only one pending: it is re-granted. `last` is unchanged and `hold_cnt` restarts at 0.

## Test plan
- Reset with `req`=4'b1111 held, `rst` released at cycle 0:
  - `gnt`=0001 in cycle 1.
  - 0001 held 8 cycles, then GAP with `preempt`=1.
  - Then 0010, 0100, 1000, 0001 in rotation, each 8 cycles plus 1 GAP.
- Wrap and mask: with `last`=2, `req`=0011 → next grant 0001; with `last`=0, `req`=1001 → grant 1000.
- Early release: only `req[2]` high for 3 cycles, then low:
  - `gnt`=0100 for 3 cycles, then 0 in the following cycle.
  - `preempt` stays 0.
- Sole requester: `req`=0100 held for 20 cycles → `gnt`=0100 continuously, no GAP, `hold_cnt` saturated.
- Reset mid-grant: `rst`=1 while `gnt`=0010 → `gnt`=0 next cycle. After release with `req`=0110, `gnt`=0010 first (`last` was reset to 3).
- `max_hold`=1 and `request_lines`=3 with `req`=111: grant sequence 001,0,010,0,100,0,001; `preempt` pulses in every GAP cycle.
